sfifo_wb_if: RTL and testbench
==============================

SFIFO_WB_IF -- requirements
Module: sfifo_wb_if

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- WB_AW, 6: address width; word register index is wb_adr_i[WB_AW-1:2].
- WB_DW, 32: data width.
- SFIFO_DW, 16: sync-FIFO data width, range 1..32.
- DOUT_N, 16: output channel count, range 1..64.
- DIN_N, 32: input channel count, range 1..32.
- RD_TIMEOUT, 255: maximum wait cycles on an empty-FIFO read, range 1..65535.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- wb_clk_i, in, 1: the single clock.
- wb_rst_i, in, 1: reset, asynchronous, active-high.
- wb_cyc_i, in, 1; wb_stb_i, in, 1; wb_we_i, in, 1; wb_sel_i, in, 4: WISHBONE controls.
- wb_adr_i, in, WB_AW-2: word address.
- wb_dat_i, in, WB_DW: write data.
- wb_dat_o, out, WB_DW: read data.
- wb_ack_o, out, 1: acknowledge.
- sfifo_rd_o, out, 1: FIFO pop pulse.
- sfifo_empty_i, in, 1: FIFO empty.
- sfifo_di, in, SFIFO_DW: FIFO head data (first-word-fall-through, valid while not empty).
- sfifo_bp_tick_i, in, 1: asynchronous base-period tick level.
- dout_set_o, out, DOUT_N: per-channel set pulses.
- dout_rst_o, out, DOUT_N: per-channel reset pulses.
- din_i, in, DIN_N: asynchronous digital inputs.
- irq_o, out, 1: level interrupt.

Function
REQ-003 The block SHALL use the following register map (word index):
- 0 BP_TICK: RO.
- 1 STATUS: bit0 empty RO; bit1 timeout sticky, W1C.
- 2 DI: RO, pop.
- 3 DOUT_CMD: WO.
- 4 DOUT_SET: WO mask.
- 5 DOUT_RST: WO mask.
- 6 DIN: RO.
- 7 DIN_EDGE: RO, W1C.
- 8 IRQ_EN: RW, bit0.
- Other indices: reads return 0; writes are ignored.

REQ-004 A request SHALL be wb_cyc_i & wb_stb_i; for every index except DI, wb_ack_o SHALL assert for exactly one cycle on the edge after the request is first sampled, and SHALL be low the following cycle (no back-to-back ack).

REQ-005 Read data SHALL be registered onto wb_dat_o on the same edge that wb_ack_o rises; unused upper bits SHALL be 0.

REQ-006 Writes SHALL take effect only when wb_sel_i == 4'hF; writes with a partial wb_sel_i SHALL be acked and otherwise ignored.

REQ-007 sfifo_bp_tick_i SHALL pass through a 2-flop synchroniser; each synchronised rising edge SHALL increment the 32-bit BP_TICK counter, which wraps 0xFFFFFFFF -> 0.

REQ-008 din_i SHALL pass through a 2-flop synchroniser; a DIN read SHALL return the synchronised value, zero-extended.

REQ-009 A synchronised 0->1 transition on din[k] SHALL set DIN_EDGE[k]; a W1C write SHALL clear the written bits, except that a set and a clear of the same bit in the same cycle SHALL leave the bit set.

REQ-010 irq_o SHALL be registered and equal IRQ_EN[0] & (|DIN_EDGE).

REQ-011 The DI read FSM SHALL have three states, IDLE, WAIT and DONE, with these transitions:
- IDLE: on a DI read with sfifo_empty_i=0, the block SHALL register wb_dat_o={sfifo_di, zeros} (left-justified), assert sfifo_rd_o and wb_ack_o for one cycle, and go to DONE.
- IDLE: on a DI read with sfifo_empty_i=1, the block SHALL load the wait counter with 0 and go to WAIT.
- WAIT: the counter SHALL increment each cycle. When empty=0, the block SHALL pop and ack as from IDLE. When the counter reaches RD_TIMEOUT, it SHALL ack with wb_dat_o=0, assert no pop, set STATUS.timeout, and go to DONE.
- WAIT: if the request is dropped, the block SHALL return to IDLE with no ack and no pop.
- DONE: the block SHALL return to IDLE the next cycle.

REQ-012 Each acked DI read SHALL pop exactly one FIFO word, and sfifo_rd_o SHALL never assert while sfifo_empty_i=1.

REQ-013 A DOUT_CMD write SHALL use bit31 as enable, bit30 as value, and bits[29:24] as index idx. If enable=1 and idx<DOUT_N, the block SHALL pulse dout_set_o[idx]=value and dout_rst_o[idx]=~value for one cycle. Otherwise there SHALL be no pulse.

REQ-014 A DOUT_SET or DOUT_RST write SHALL pulse dout_set_o or dout_rst_o respectively with wb_dat_i[DOUT_N-1:0] for one cycle. For DOUT_N>32, bits 32 and above SHALL be reachable only through DOUT_CMD.

REQ-015 Every bit of dout_set_o and dout_rst_o SHALL be 0 in all cycles other than the pulse cycle, and the two outputs SHALL never be both 1 for the same channel.

REQ-016 STATUS.timeout W1C SHALL follow the same rule as REQ-009: a set and a clear in the same cycle leave the bit set.

Reset
REQ-017 While wb_rst_i=1, asynchronously, the block SHALL drive:
- wb_ack_o=0, wb_dat_o=0, sfifo_rd_o=0, dout_set_o=0, dout_rst_o=0, irq_o=0.
- BP_TICK=0, DIN_EDGE=0, IRQ_EN=0, STATUS.timeout=0.
- Synchronisers to 0, FSM to IDLE.

REQ-018 Reset asserted during WAIT SHALL abort the read, with no ack and no pop after release.

Verification
REQ-019 FIFO holding 0x1234, read DI -> ack 1 cycle after the request, wb_dat_o=0x12340000, one sfifo_rd_o pulse.

REQ-020 Empty FIFO, read DI, FIFO fills 5 cycles later -> ack with the data and exactly one pop. With the FIFO kept empty and RD_TIMEOUT=8 -> ack with 0 after 8 wait cycles and STATUS=0x3; then writing 0x2 to STATUS clears the timeout bit.

REQ-021 Write 0xC5000000 to DOUT_CMD -> dout_set_o[5]=1 for one cycle. Write 0x85000000 -> dout_rst_o[5]=1. Index 63 with DOUT_N=16 -> no pulse.

REQ-022 Eight tick rising edges -> BP_TICK=8. Forcing the counter to 0xFFFFFFFF, then one edge -> 0.

REQ-023 din_i[3] rises with IRQ_EN=1 -> DIN_EDGE=0x8 and irq_o=1. Write-1 to bit 3 in the same cycle as a new edge on bit 3 -> bit stays set. A later clear -> irq_o=0.

REQ-024 Reset pulsed mid-WAIT -> all outputs 0 immediately, and no pop or ack after release.

Source files
------------

// File: rtl/sfifo_wb_if.sv
// WISHBONE register slave: reads a first-word-fall-through sync FIFO with a bounded wait,
// drives per-channel DOUT set/reset pulses, samples DIN with edge capture and counts ticks.
module sfifo_wb_if #(
    parameter int WB_AW      = 6,
    parameter int WB_DW      = 32,
    parameter int SFIFO_DW   = 16,
    parameter int DOUT_N     = 16,
    parameter int DIN_N      = 32,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [3:0]          wb_sel_i,
    input  logic [WB_AW-3:0]    wb_adr_i,
    input  logic [WB_DW-1:0]    wb_dat_i,
    output logic [WB_DW-1:0]    wb_dat_o,
    output logic                wb_ack_o,
    output logic                sfifo_rd_o,
    input  logic                sfifo_empty_i,
    input  logic [SFIFO_DW-1:0] sfifo_di,
    input  logic                sfifo_bp_tick_i,
    output logic [DOUT_N-1:0]   dout_set_o,
    output logic [DOUT_N-1:0]   dout_rst_o,
    input  logic [DIN_N-1:0]    din_i,
    output logic                irq_o
);

    localparam int IDX_BP_TICK  = 0;
    localparam int IDX_STATUS   = 1;
    localparam int IDX_DI       = 2;
    localparam int IDX_DOUT_CMD = 3;
    localparam int IDX_DOUT_SET = 4;
    localparam int IDX_DOUT_RST = 5;
    localparam int IDX_DIN      = 6;
    localparam int IDX_DIN_EDGE = 7;
    localparam int IDX_IRQ_EN   = 8;
    localparam logic [15:0] TO_LAST = 16'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } rd_state_e;

    rd_state_e          state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               ack_q, ack_d;
    logic               rd_q, rd_d;
    logic [WB_DW-1:0]   dat_q, dat_d;
    logic [DOUT_N-1:0]  set_q, set_d;
    logic [DOUT_N-1:0]  rst_q, rst_d;
    logic               irq_q, irq_d;
    logic               irq_en_q, irq_en_d;
    logic               timeout_q, timeout_d;
    logic [2:0]         bp_sync_q, bp_sync_d;
    logic [31:0]        bp_cnt_q, bp_cnt_d;
    logic [DIN_N-1:0]   din_s1_q, din_s1_d;
    logic [DIN_N-1:0]   din_s2_q, din_s2_d;
    logic [DIN_N-1:0]   din_s3_q, din_s3_d;
    logic [DIN_N-1:0]   din_edge_q, din_edge_d;

    logic               req;
    logic               di_rd;
    logic [31:0]        adr_idx;
    logic [WB_DW-1:0]   di_word;
    logic [WB_DW-1:0]   rd_mux;
    logic               bus_wr;
    logic               wr_full;
    logic               timeout_set;
    logic               to_clr;
    logic [DIN_N-1:0]   din_clr;
    logic               bp_rise;
    logic [DIN_N-1:0]   din_rise;

    // A bus cycle is a request while cyc&stb are high; the slave answers with a
    // single-cycle ack and then idles one cycle, so a held request is acked every other cycle.
    assign req     = wb_cyc_i & wb_stb_i;
    assign adr_idx = 32'(wb_adr_i);
    assign di_rd   = req & ~wb_we_i & (adr_idx == IDX_DI);
    assign di_word = WB_DW'(sfifo_di) << (WB_DW - SFIFO_DW);

    assign bp_sync_d = {bp_sync_q[1:0], sfifo_bp_tick_i};
    assign bp_rise   = bp_sync_q[1] & ~bp_sync_q[2];
    assign din_s1_d  = din_i;
    assign din_s2_d  = din_s1_q;
    assign din_s3_d  = din_s2_q;
    assign din_rise  = din_s2_q & ~din_s3_q;

    always_comb begin
        rd_mux = '0;
        case (adr_idx)
            IDX_BP_TICK:  rd_mux = WB_DW'(bp_cnt_q);
            IDX_STATUS:   rd_mux = WB_DW'({timeout_q, sfifo_empty_i});
            IDX_DIN:      rd_mux = WB_DW'(din_s2_q);
            IDX_DIN_EDGE: rd_mux = WB_DW'(din_edge_q);
            IDX_IRQ_EN:   rd_mux = WB_DW'(irq_en_q);
            default:      rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ack_d       = 1'b0;
        rd_d        = 1'b0;
        dat_d       = '0;
        bus_wr      = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && !ack_q) begin
                    if (di_rd) begin
                        if (!sfifo_empty_i) begin
                            ack_d   = 1'b1;
                            rd_d    = 1'b1;
                            dat_d   = di_word;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_WAIT;
                        end
                    end else begin
                        ack_d  = 1'b1;
                        bus_wr = wb_we_i;
                        if (!wb_we_i) dat_d = rd_mux;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (!di_rd) begin
                    state_d = ST_IDLE;
                end else if (!sfifo_empty_i) begin
                    ack_d   = 1'b1;
                    rd_d    = 1'b1;
                    dat_d   = di_word;
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    ack_d       = 1'b1;
                    timeout_set = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_full  = bus_wr && (wb_sel_i == 4'hF);
        set_d    = '0;
        rst_d    = '0;
        irq_en_d = irq_en_q;
        to_clr   = 1'b0;
        din_clr  = '0;
        if (wr_full) begin
            case (adr_idx)
                IDX_STATUS: to_clr = wb_dat_i[1];
                IDX_DOUT_CMD: begin
                    for (int k = 0; k < DOUT_N; k++) begin
                        if (wb_dat_i[31] && (int'(wb_dat_i[29:24]) == k)) begin
                            set_d[k] = wb_dat_i[30];
                            rst_d[k] = ~wb_dat_i[30];
                        end
                    end
                end
                IDX_DOUT_SET: begin
                    for (int k = 0; k < DOUT_N; k++) begin
                        if (k < WB_DW) set_d[k] = wb_dat_i[k];
                    end
                end
                IDX_DOUT_RST: begin
                    for (int k = 0; k < DOUT_N; k++) begin
                        if (k < WB_DW) rst_d[k] = wb_dat_i[k];
                    end
                end
                IDX_DIN_EDGE: din_clr  = wb_dat_i[DIN_N-1:0];
                IDX_IRQ_EN:   irq_en_d = wb_dat_i[0];
                default: ;
            endcase
        end
        // A fresh set outranks a simultaneous write-1-to-clear so no event is lost.
        timeout_d  = (timeout_q & ~to_clr) | timeout_set;
        din_edge_d = (din_edge_q & ~din_clr) | din_rise;
        irq_d      = irq_en_q & (|din_edge_q);
        bp_cnt_d   = bp_cnt_q + 32'(bp_rise);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            rd_q       <= 1'b0;
            dat_q      <= '0;
            set_q      <= '0;
            rst_q      <= '0;
            irq_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            timeout_q  <= 1'b0;
            bp_sync_q  <= '0;
            bp_cnt_q   <= '0;
            din_s1_q   <= '0;
            din_s2_q   <= '0;
            din_s3_q   <= '0;
            din_edge_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            rd_q       <= rd_d;
            dat_q      <= dat_d;
            set_q      <= set_d;
            rst_q      <= rst_d;
            irq_q      <= irq_d;
            irq_en_q   <= irq_en_d;
            timeout_q  <= timeout_d;
            bp_sync_q  <= bp_sync_d;
            bp_cnt_q   <= bp_cnt_d;
            din_s1_q   <= din_s1_d;
            din_s2_q   <= din_s2_d;
            din_s3_q   <= din_s3_d;
            din_edge_q <= din_edge_d;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign sfifo_rd_o = rd_q;
    assign dout_set_o = set_q;
    assign dout_rst_o = rst_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_sfifo_wb_if.sv
// Self-checking bench for sfifo_wb_if: register-map vector table plus hand-built
// sequences for the FIFO wait/timeout, tick wrap, DIN edge/IRQ and mid-wait reset.
module tb_sfifo_wb_if;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i  = 1'b0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic [3:0]  wb_adr_i = 4'h0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        sfifo_rd_o;
    logic        sfifo_empty_i = 1'b1;
    logic [15:0] sfifo_di = '0;
    logic        sfifo_bp_tick_i = 1'b0;
    logic [15:0] dout_set_o;
    logic [15:0] dout_rst_o;
    logic [31:0] din_i = '0;
    logic        irq_o;

    sfifo_wb_if #(.RD_TIMEOUT(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .sfifo_rd_o(sfifo_rd_o),
        .sfifo_empty_i(sfifo_empty_i), .sfifo_di(sfifo_di), .sfifo_bp_tick_i(sfifo_bp_tick_i),
        .dout_set_o(dout_set_o), .dout_rst_o(dout_rst_o), .din_i(din_i), .irq_o(irq_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- FIFO model and monitors ----------------
    logic [15:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int cmp_cnt = 0;
    int fail_cnt = 0;
    int pop_cnt = 0;
    int ack_cnt = 0;
    int rd_empty_viol = 0;
    int both_viol = 0;
    logic [15:0] ack_set, ack_rst;

    always @(negedge wb_clk_i) begin
        if (sfifo_rd_o) begin
            pop_cnt++;
            if (sfifo_empty_i) rd_empty_viol++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        if (wb_ack_o) ack_cnt++;
        if ((dout_set_o & dout_rst_o) != 16'h0) both_viol++;
        sfifo_empty_i = (fifo_q.size() == 0);
        sfifo_di = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0;
    end

    // ---------------- scoreboard / driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                        input logic [3:0] sel, input logic [31:0] exp_rd,
                        input logic [15:0] exp_set, input logic [15:0] exp_rst,
                        input int exp_lat, input string name);
        int lat;
        bit got;
        logic [31:0] e;
        if (!we) exp_q.push_back(exp_rd);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = wdat; wb_sel_i = sel;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge wb_clk_i);
            #1;
            lat++;
            if (wb_ack_o) got = 1'b1;
        end
        ack_set = dout_set_o;
        ack_rst = dout_rst_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        check({name, " ack latency"}, 64'(lat), 64'(exp_lat));
        if (!we) begin
            e = exp_q.pop_front();
            if (got) check({name, " rdata"}, 64'(wb_dat_o), 64'(e));
        end
        check({name, " dout pulse"}, {32'h0, ack_set, ack_rst}, {32'h0, exp_set, exp_rst});
        @(posedge wb_clk_i);
        #1;
        check({name, " after ack"}, {46'h0, wb_ack_o, sfifo_rd_o, dout_set_o | dout_rst_o},
              64'h0);
    endtask

    task automatic tick_edge();
        sfifo_bp_tick_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        sfifo_bp_tick_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic [15:0] exp_set;
        logic [15:0] exp_rst;
        string       name;
    } vec_t;

    vec_t vecs[26];

    initial begin
        logic a0, a1, a2;
        int pop0, ack0;

        vecs = '{
            '{1'b0, 4'd0,  32'h0,        4'hF, 32'h0, 16'h0,    16'h0,    "rd_bp0"},
            '{1'b0, 4'd1,  32'h0,        4'hF, 32'h1, 16'h0,    16'h0,    "rd_status0"},
            '{1'b0, 4'd8,  32'h0,        4'hF, 32'h0, 16'h0,    16'h0,    "rd_irqen0"},
            '{1'b1, 4'd8,  32'h1,        4'hF, 32'h0, 16'h0,    16'h0,    "wr_irqen1"},
            '{1'b0, 4'd8,  32'h0,        4'hF, 32'h1, 16'h0,    16'h0,    "rd_irqen1"},
            '{1'b1, 4'd8,  32'h0,        4'h3, 32'h0, 16'h0,    16'h0,    "wr_irqen_part"},
            '{1'b0, 4'd8,  32'h0,        4'hF, 32'h1, 16'h0,    16'h0,    "rd_irqen_kept"},
            '{1'b1, 4'd8,  32'h0,        4'hF, 32'h0, 16'h0,    16'h0,    "wr_irqen0"},
            '{1'b0, 4'd8,  32'h0,        4'hF, 32'h0, 16'h0,    16'h0,    "rd_irqen_clr"},
            '{1'b0, 4'd3,  32'h0,        4'hF, 32'h0, 16'h0,    16'h0,    "rd_dout_cmd"},
            '{1'b1, 4'd12, 32'hFFFFFFFF, 4'hF, 32'h0, 16'h0,    16'h0,    "wr_idx12"},
            '{1'b0, 4'd12, 32'h0,        4'hF, 32'h0, 16'h0,    16'h0,    "rd_idx12"},
            '{1'b0, 4'd6,  32'h0,        4'hF, 32'h0, 16'h0,    16'h0,    "rd_din0"},
            '{1'b0, 4'd7,  32'h0,        4'hF, 32'h0, 16'h0,    16'h0,    "rd_edge0"},
            '{1'b1, 4'd3,  32'hC5000000, 4'hF, 32'h0, 16'h0020, 16'h0,    "cmd_set5"},
            '{1'b1, 4'd3,  32'h85000000, 4'hF, 32'h0, 16'h0,    16'h0020, "cmd_rst5"},
            '{1'b1, 4'd3,  32'hFF000000, 4'hF, 32'h0, 16'h0,    16'h0,    "cmd_idx63"},
            '{1'b1, 4'd3,  32'h45000000, 4'hF, 32'h0, 16'h0,    16'h0,    "cmd_disabled"},
            '{1'b1, 4'd3,  32'hCF000000, 4'hF, 32'h0, 16'h8000, 16'h0,    "cmd_set15"},
            '{1'b1, 4'd3,  32'hD0000000, 4'hF, 32'h0, 16'h0,    16'h0,    "cmd_idx16"},
            '{1'b1, 4'd3,  32'h8F000000, 4'hF, 32'h0, 16'h0,    16'h8000, "cmd_rst15"},
            '{1'b1, 4'd4,  32'h0000A5A5, 4'hF, 32'h0, 16'hA5A5, 16'h0,    "set_mask"},
            '{1'b1, 4'd5,  32'h12345678, 4'hF, 32'h0, 16'h0,    16'h5678, "rst_mask"},
            '{1'b1, 4'd4,  32'hFFFFFFFF, 4'h7, 32'h0, 16'h0,    16'h0,    "set_part_sel"},
            '{1'b0, 4'd4,  32'h0,        4'hF, 32'h0, 16'h0,    16'h0,    "rd_dout_set"},
            '{1'b1, 4'd2,  32'hFFFFFFFF, 4'hF, 32'h0, 16'h0,    16'h0,    "wr_di_ignored"}
        };

        // ---------------- reset ----------------
        repeat (2) @(posedge wb_clk_i);
        #1;
        check("reset outputs", {13'h0, wb_ack_o, sfifo_rd_o, irq_o, dout_set_o, dout_rst_o},
              64'h0);
        check("reset rdata", 64'(wb_dat_o), 64'h0);
        wb_rst_i = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;

        // ---------------- table ----------------
        for (int i = 0; i < 26; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].sel, vecs[i].exp_rd,
                 vecs[i].exp_set, vecs[i].exp_rst, 1, vecs[i].name);
        end
        check("di write pops", 64'(pop_cnt), 64'h0);

        // ---------------- held request: ack, gap, ack ----------------
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'd8; wb_sel_i = 4'hF;
        @(posedge wb_clk_i); #1; a0 = wb_ack_o;
        @(posedge wb_clk_i); #1; a1 = wb_ack_o;
        @(posedge wb_clk_i); #1; a2 = wb_ack_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check("held req ack pattern", 64'({a0, a1, a2}), 64'b101);
        @(posedge wb_clk_i); #1;

        // ---------------- DI read, FIFO non-empty ----------------
        fifo_q.push_back(16'h1234);
        @(negedge wb_clk_i);
        pop0 = pop_cnt;
        xfer(1'b0, 4'd2, 32'h0, 4'hF, 32'h12340000, 16'h0, 16'h0, 1, "di_ready");
        check("di_ready pops", 64'(pop_cnt - pop0), 64'd1);

        // ---------------- DI read, FIFO fills 5 cycles later ----------------
        pop0 = pop_cnt;
        fork
            xfer(1'b0, 4'd2, 32'h0, 4'hF, 32'hBEEF0000, 16'h0, 16'h0, 6, "di_late");
            begin
                repeat (5) @(posedge wb_clk_i);
                #1;
                fifo_q.push_back(16'hBEEF);
            end
        join
        check("di_late pops", 64'(pop_cnt - pop0), 64'd1);

        // ---------------- DI read timeout ----------------
        pop0 = pop_cnt;
        xfer(1'b0, 4'd2, 32'h0, 4'hF, 32'h0, 16'h0, 16'h0, 9, "di_timeout");
        check("di_timeout pops", 64'(pop_cnt - pop0), 64'd0);
        xfer(1'b0, 4'd1, 32'h0, 4'hF, 32'h3, 16'h0, 16'h0, 1, "status_to");
        xfer(1'b1, 4'd1, 32'h2, 4'hC, 32'h0, 16'h0, 16'h0, 1, "status_w1c_part");
        xfer(1'b0, 4'd1, 32'h0, 4'hF, 32'h3, 16'h0, 16'h0, 1, "status_to_kept");
        xfer(1'b1, 4'd1, 32'h2, 4'hF, 32'h0, 16'h0, 16'h0, 1, "status_w1c");
        xfer(1'b0, 4'd1, 32'h0, 4'hF, 32'h1, 16'h0, 16'h0, 1, "status_clr");

        // ---------------- BP tick counter ----------------
        for (int i = 0; i < 8; i++) tick_edge();
        xfer(1'b0, 4'd0, 32'h0, 4'hF, 32'h8, 16'h0, 16'h0, 1, "bp_tick8");
        force dut.bp_cnt_q = 32'hFFFFFFFF;
        @(posedge wb_clk_i);
        #1;
        release dut.bp_cnt_q;
        tick_edge();
        xfer(1'b0, 4'd0, 32'h0, 4'hF, 32'h0, 16'h0, 16'h0, 1, "bp_tick_wrap");

        // ---------------- DIN edge / IRQ ----------------
        xfer(1'b1, 4'd8, 32'h1, 4'hF, 32'h0, 16'h0, 16'h0, 1, "irq_en_on");
        din_i[3] = 1'b1;
        repeat (4) @(posedge wb_clk_i);
        #1;
        check("irq on edge", 64'(irq_o), 64'd1);
        xfer(1'b0, 4'd7, 32'h0, 4'hF, 32'h8, 16'h0, 16'h0, 1, "din_edge3");
        xfer(1'b0, 4'd6, 32'h0, 4'hF, 32'h8, 16'h0, 16'h0, 1, "din_level3");
        xfer(1'b1, 4'd7, 32'h8, 4'hF, 32'h0, 16'h0, 16'h0, 1, "din_edge_clr");
        xfer(1'b0, 4'd7, 32'h0, 4'hF, 32'h0, 16'h0, 16'h0, 1, "din_edge_cleared");
        check("irq after clear", 64'(irq_o), 64'd0);
        din_i[3] = 1'b0;
        repeat (4) @(posedge wb_clk_i);
        #1;
        din_i[3] = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #1;
        // The write's ack edge coincides with the synchronised rise on bit 3.
        xfer(1'b1, 4'd7, 32'h8, 4'hF, 32'h0, 16'h0, 16'h0, 1, "din_set_vs_clr");
        xfer(1'b0, 4'd7, 32'h0, 4'hF, 32'h8, 16'h0, 16'h0, 1, "din_edge_kept");
        check("irq after set_vs_clr", 64'(irq_o), 64'd1);

        // ---------------- reset in the middle of a DI wait ----------------
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'd2; wb_sel_i = 4'hF;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("wait no ack", 64'(wb_ack_o), 64'd0);
        pop0 = pop_cnt;
        ack0 = ack_cnt;
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("mid-wait reset outputs",
              {13'h0, wb_ack_o, sfifo_rd_o, irq_o, dout_set_o, dout_rst_o}, 64'h0);
        check("mid-wait reset rdata", 64'(wb_dat_o), 64'h0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        fifo_q.push_back(16'hA5A5);
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        repeat (20) @(posedge wb_clk_i);
        #1;
        check("post-reset acks", 64'(ack_cnt - ack0), 64'd0);
        check("post-reset pops", 64'(pop_cnt - pop0), 64'd0);
        xfer(1'b0, 4'd8, 32'h0, 4'hF, 32'h0, 16'h0, 16'h0, 1, "post_rst_irqen");
        xfer(1'b0, 4'd0, 32'h0, 4'hF, 32'h0, 16'h0, 16'h0, 1, "post_rst_bp");
        xfer(1'b0, 4'd1, 32'h0, 4'hF, 32'h0, 16'h0, 16'h0, 1, "post_rst_status");
        check("post-reset irq", 64'(irq_o), 64'd0);
        pop0 = pop_cnt;
        xfer(1'b0, 4'd2, 32'h0, 4'hF, 32'hA5A50000, 16'h0, 16'h0, 1, "post_rst_di");
        check("post_rst_di pops", 64'(pop_cnt - pop0), 64'd1);

        // ---------------- global invariants ----------------
        check("pop while empty", 64'(rd_empty_viol), 64'd0);
        check("set and rst same channel", 64'(both_viol), 64'd0);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
